timer_sequencer: RTL

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

---
 rtl/timer_pkg.sv | 28 ++
 rtl/timer.sv | 54 +++++
 rtl/wd_counter.sv | 31 +++
 rtl/timer_sequencer.sv | 103 ++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and default constants for the timer sequencer and its downstream timer.
package timer_pkg;

    localparam int W_DEFAULT       = 8;
    localparam int TIMEOUT_DEFAULT = 16;
    localparam int TIMER_N_DEFAULT = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_FIN   = 3'd4,
        S_ERR   = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_RUN  = 2'd1,
        T_DONE = 2'd2
    } timer_state_t;

    // Counter width able to hold values 0..limit-1 with one bit of headroom.
    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/timer.sv
// Downstream fixed-length timer: START accepted in idle gives an RDY pulse N cycles later.
module timer
    import timer_pkg::*;
#(
    parameter int N = TIMER_N_DEFAULT
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         START,
    output logic         RDY,
    output timer_state_t DBG_STATE
);

    localparam int CW = cnt_width(N);

    timer_state_t  state;
    timer_state_t  state_next;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state <= T_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            T_IDLE:  if (START) state_next = T_RUN;
            T_RUN:   if (cnt == CW'(N - 2)) state_next = T_DONE;
            T_DONE:  state_next = T_IDLE;
            default: state_next = T_IDLE;
        endcase
    end

    // RUN spans N-1 cycles and DONE one more, so RDY lands N cycles after the START cycle.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            cnt <= '0;
        end else if (state == T_IDLE) begin
            cnt <= '0;
        end else if (state == T_RUN) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        RDY       = (state == T_DONE);
        DBG_STATE = state;
    end

endmodule

// File: rtl/wd_counter.sv
// Watchdog counter: counts enabled cycles and flags expiry at TIMEOUT-1.
module wd_counter
    import timer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic CLK,
    input  logic N_RESET,
    input  logic CLR,
    input  logic EN,
    output logic EXPIRED
);

    localparam int CW = cnt_width(TIMEOUT);

    logic [CW-1:0] count;

    assign EXPIRED = (count == CW'(TIMEOUT - 1));

    // Saturates at the expiry value so the count can never wrap.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            count <= '0;
        end else if (CLR) begin
            count <= '0;
        end else if (EN && !EXPIRED) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Runs a downstream timer REPS times back to back, with a watchdog on each wait for RDY.
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         GO,
    input  logic [W-1:0] REPS,
    input  logic         ABORT,
    input  logic         RDY,
    output logic         START,
    output logic         BUSY,
    output logic         DONE,
    output logic         FAULT,
    output logic [W-1:0] REP_COUNT,
    output seq_state_t   DBG_STATE
);

    // Handshake with the timer: START is a one-cycle request issued only once the
    // timer is known idle (after GAP); RDY is a one-cycle completion honoured only in WAIT.

    seq_state_t   state;
    seq_state_t   state_next;
    logic [W-1:0] target;
    logic [W-1:0] rep_count;
    logic         go_accept;
    logic         rdy_accept;
    logic         last_run;
    logic         wd_expired;

    assign go_accept  = (state == S_IDLE) && GO && !ABORT;
    assign rdy_accept = (state == S_WAIT) && RDY && !ABORT;
    assign last_run   = ((rep_count + W'(1)) == target);

    wd_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .CLR     (state == S_ISSUE),
        .EN      ((state == S_WAIT) && !RDY),
        .EXPIRED (wd_expired)
    );

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ABORT outranks GO and RDY; RDY outranks a simultaneous watchdog expiry.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (go_accept) begin
                    state_next = (REPS != '0) ? S_ISSUE : S_FIN;
                end
            end
            S_ISSUE: state_next = ABORT ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (ABORT) begin
                    state_next = S_IDLE;
                end else if (RDY) begin
                    state_next = last_run ? S_FIN : S_GAP;
                end else if (wd_expired) begin
                    state_next = S_ERR;
                end
            end
            S_GAP:   state_next = ABORT ? S_IDLE : S_ISSUE;
            S_FIN:   state_next = S_IDLE;
            S_ERR:   state_next = ABORT ? S_IDLE : S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            target    <= '0;
            rep_count <= '0;
        end else if (go_accept) begin
            target    <= REPS;
            rep_count <= '0;
        end else if (rdy_accept) begin
            rep_count <= rep_count + W'(1);
        end
    end

    always_comb begin
        START     = (state == S_ISSUE);
        BUSY      = (state == S_ISSUE) || (state == S_WAIT) || (state == S_GAP);
        DONE      = (state == S_FIN);
        FAULT     = (state == S_ERR);
        REP_COUNT = rep_count;
        DBG_STATE = state;
    end

endmodule
